dsp_bus_arbiter: RTL and testbench

DSP_BUS_ARBITER -- requirements
Module: dsp_bus_arbiter

---
 rtl/dsp_bus_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/dsp_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_dsp_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_bus_pkg.sv
// Shared types and widths for the DSP bus arbiter: bus-cycle state encoding
// and the address/data widths of the external DSP bus.
package dsp_bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: the search begins just after last_grant
// and wraps, so the most recently served requester has the lowest priority.
module rr_arbiter
    import dsp_bus_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    // Two passes: indices above last_grant first, then the wrapped-around part.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && (i > int'(last_grant)) && req[i]) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && (i <= int'(last_grant)) && req[i]) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dsp_bus_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single asynchronous-style DSP bus
// (N_CS/N_DS strobes); one bus cycle in flight, every output registered.
module dsp_bus_arbiter
    import dsp_bus_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      Clk,
    input  logic                      N_Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rnw,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      Start,
    output logic                      N_CS,
    output logic                      N_DS,
    output logic                      R_NW,
    output logic [ADDR_W-1:0]         AddrBus,
    output logic [DATA_W-1:0]         DataOut,
    output logic                      DataOE,
    input  logic [DATA_W-1:0]         DataIn,
    output logic [1:0]                dbg_state
);

    localparam int         IDX_W       = $clog2(NUM_REQ);
    localparam logic [3:0] STROBE_LOAD = 4'(WAIT_CYCLES - 1);

    bus_state_t         state, next_state;
    logic [3:0]         cnt, cnt_d;
    logic [IDX_W-1:0]   last_grant;
    logic [NUM_REQ-1:0] grant_q;
    logic               rnw_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_rnw;

    logic               take_grant;
    logic               capture;
    logic               cur_rnw;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Mux the winning requester's fields so they can be latched on the grant edge.
    always_comb begin
        arb_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rnw   = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                arb_idx   = IDX_W'(i);
                sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
                sel_wdata = req_wdata[DATA_W*i +: DATA_W];
                sel_rnw   = req_rnw[i];
            end
        end
    end

    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        take_grant = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    take_grant = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                cnt_d      = STROBE_LOAD;
                next_state = STROBE;
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    capture    = rnw_q;
                    next_state = HOLD;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            HOLD: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        cur_rnw = take_grant ? sel_rnw : rnw_q;
    end

    // Outputs are decoded from next_state so they line up with the state register.
    always_ff @(posedge Clk) begin
        if (!N_Reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant_q    <= '0;
            rnw_q      <= 1'b1;
            AddrBus    <= '0;
            DataOut    <= '0;
            rdata      <= '0;
            N_CS       <= 1'b1;
            N_DS       <= 1'b1;
            R_NW       <= 1'b1;
            DataOE     <= 1'b0;
            Start      <= 1'b0;
            ack        <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_d;
            if (take_grant) begin
                grant_q    <= arb_grant;
                last_grant <= arb_idx;
                rnw_q      <= sel_rnw;
                AddrBus    <= sel_addr;
                if (!sel_rnw) begin
                    DataOut <= sel_wdata;
                end
            end
            if (capture) begin
                rdata <= DataIn;
            end
            N_CS   <= (next_state == IDLE);
            N_DS   <= (next_state != STROBE);
            Start  <= (next_state == SETUP);
            R_NW   <= (next_state == IDLE) ? 1'b1 : cur_rnw;
            DataOE <= (next_state != IDLE) && !cur_rnw;
            ack    <= (next_state == HOLD) ? grant_q : '0;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_dsp_bus_arbiter.sv
// Directed bench for dsp_bus_arbiter: a main WAIT_CYCLES=2 instance checked
// against a bus-cycle scoreboard, plus WAIT_CYCLES=1 and 15 instances for strobe length.
module tb_dsp_bus_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WAIT_MAIN = 2;
  localparam int EXP_W     = 29;

  logic                   Clk;
  logic                   N_Reset;
  logic [NUM_REQ-1:0]     req, req_rnw, r1v, r15v;
  logic [8*NUM_REQ-1:0]   req_addr, req_wdata;

  logic [NUM_REQ-1:0]     ack;
  logic [7:0]             rdata, AddrBus, DataOut, DataIn;
  logic                   Start, N_CS, N_DS, R_NW, DataOE;
  logic [1:0]             dbg_state;

  logic [NUM_REQ-1:0]     a1_ack, a15_ack;
  logic [7:0]             a1_rdata, a1_addr, a1_dout, a15_rdata, a15_addr, a15_dout;
  logic                   a1_start, a1_ncs, a1_nds, a1_rnw, a1_oe;
  logic                   a15_start, a15_ncs, a15_nds, a15_rnw, a15_oe;
  logic [1:0]             a1_dbg, a15_dbg;
  logic [7:0]             din_1, din_15;

  logic [EXP_W-1:0]       exp_q[$];
  int                     checks = 0;
  int                     passed = 0;
  int                     start_cnt = 0;
  int                     ds1_checks = 0;
  int                     ds15_checks = 0;
  logic [7:0]             last_rd = 8'h00;

  // The DSP answers reads with a fixed function of the address.
  assign DataIn = !N_DS ? (AddrBus ^ 8'h4A) : 8'h00;
  assign din_1  = 8'h00;
  assign din_15 = 8'h00;

  dsp_bus_arbiter #(.NUM_REQ(NUM_REQ), .WAIT_CYCLES(WAIT_MAIN)) dut (
    .Clk(Clk), .N_Reset(N_Reset), .req(req), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .Start(Start), .N_CS(N_CS), .N_DS(N_DS), .R_NW(R_NW), .AddrBus(AddrBus),
    .DataOut(DataOut), .DataOE(DataOE), .DataIn(DataIn), .dbg_state(dbg_state)
  );

  dsp_bus_arbiter #(.NUM_REQ(NUM_REQ), .WAIT_CYCLES(1)) dut_w1 (
    .Clk(Clk), .N_Reset(N_Reset), .req(r1v), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(a1_ack), .rdata(a1_rdata),
    .Start(a1_start), .N_CS(a1_ncs), .N_DS(a1_nds), .R_NW(a1_rnw), .AddrBus(a1_addr),
    .DataOut(a1_dout), .DataOE(a1_oe), .DataIn(din_1), .dbg_state(a1_dbg)
  );

  dsp_bus_arbiter #(.NUM_REQ(NUM_REQ), .WAIT_CYCLES(15)) dut_w15 (
    .Clk(Clk), .N_Reset(N_Reset), .req(r15v), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(a15_ack), .rdata(a15_rdata),
    .Start(a15_start), .N_CS(a15_ncs), .N_DS(a15_nds), .R_NW(a15_rnw), .AddrBus(a15_addr),
    .DataOut(a15_dout), .DataOE(a15_oe), .DataIn(din_15), .dbg_state(a15_dbg)
  );

  // Clock / reset-independent timeout
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks passed %0d of %0d", passed, checks);
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic set_req(input int idx, input logic rnw, input logic [7:0] addr,
                         input logic [7:0] wdata);
    req_rnw[idx]           = rnw;
    req_addr[8*idx +: 8]   = addr;
    req_wdata[8*idx +: 8]  = wdata;
  endtask

  task automatic expect_cycle(input int idx, input logic rnw, input logic [7:0] addr,
                              input logic [7:0] wdata);
    logic [3:0] oh;
    logic [7:0] rd;
    oh = 4'b0001 << idx;
    rd = rnw ? (addr ^ 8'h4A) : last_rd;
    if (rnw) last_rd = rd;
    exp_q.push_back({oh, rnw, addr, wdata, rd});
  endtask

  task automatic wait_ack(input int idx, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!ack[idx] && n < budget);
    check($sformatf("ack%0d_seen", idx), {31'd0, ack[idx]}, 32'd1);
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Start && n < budget);
    check("start_seen", {31'd0, Start}, 32'd1);
  endtask

  // Scoreboard monitor for the main instance
  int         cs_run = 0;
  int         ds_run = 0;
  int         ds_last = 0;
  logic       prev_cs = 1'b1;
  logic [EXP_W-1:0] e;

  always @(negedge Clk) begin
    if (!N_Reset) begin
      cs_run  = 0;
      ds_run  = 0;
      prev_cs = 1'b1;
    end else begin
      if (!N_CS) cs_run++; else cs_run = 0;
      if (!N_DS) ds_run++;
      else if (ds_run != 0) begin
        ds_last = ds_run;
        ds_run  = 0;
      end
      if (Start) begin
        start_cnt++;
        check("idle_gap_before_start", {31'd0, prev_cs}, 32'd1);
        if (exp_q.size() == 0) begin
          check("start_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q[0];
          check("setup_addr", {24'd0, AddrBus}, {24'd0, e[23:16]});
          check("setup_rnw", {31'd0, R_NW}, {31'd0, e[24]});
          check("setup_oe", {31'd0, DataOE}, {31'd0, ~e[24]});
          check("setup_ncs_nds", {30'd0, N_CS, N_DS}, 32'd1);
          if (!e[24]) check("setup_dataout", {24'd0, DataOut}, {24'd0, e[15:8]});
        end
      end
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          check("ack_unexpected", {28'd0, ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_onehot", {28'd0, ack}, {28'd0, e[28:25]});
          check("ack_rdata", {24'd0, rdata}, {24'd0, e[7:0]});
          check("ack_addr_latched", {24'd0, AddrBus}, {24'd0, e[23:16]});
          check("ack_oe", {31'd0, DataOE}, {31'd0, ~e[24]});
          check("ncs_low_cycles", cs_run, WAIT_MAIN + 2);
          check("nds_low_cycles", ds_last, WAIT_MAIN);
        end
      end
      prev_cs = N_CS;
    end
  end

  // Strobe-length monitors for the WAIT_CYCLES=1 and 15 instances
  int run1 = 0;
  int run15 = 0;

  always @(negedge Clk) begin
    if (!N_Reset) run1 = 0;
    else if (!a1_nds) run1++;
    else if (run1 != 0) begin
      check("nds_len_w1", run1, 1);
      ds1_checks++;
      run1 = 0;
    end
  end

  always @(negedge Clk) begin
    if (!N_Reset) run15 = 0;
    else if (!a15_nds) run15++;
    else if (run15 != 0) begin
      check("nds_len_w15", run15, 15);
      ds15_checks++;
      run15 = 0;
    end
  end

  // Directed sequence
  initial begin
    int s0;
    int n;
    N_Reset   = 1'b0;
    req       = '0;
    req_rnw   = '0;
    req_addr  = '0;
    req_wdata = '0;
    r1v       = '0;
    r15v      = '0;
    repeat (3) @(negedge Clk);
    check("rst_strobes", {29'd0, N_CS, N_DS, R_NW}, 32'd7);
    check("rst_oe_start", {30'd0, DataOE, Start}, 32'd0);
    check("rst_ack", {28'd0, ack}, 32'd0);
    check("rst_addr", {24'd0, AddrBus}, 32'd0);
    check("rst_dataout", {24'd0, DataOut}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    N_Reset = 1'b1;
    @(negedge Clk);

    // Single write from requester 0
    set_req(0, 1'b0, 8'h3C, 8'hA5);
    expect_cycle(0, 1'b0, 8'h3C, 8'hA5);
    req[0] = 1'b1;
    wait_ack(0, 20);
    req[0] = 1'b0;
    check("idle_after_write", {31'd0, N_CS}, 32'd0);
    @(negedge Clk);
    check("idle_outputs", {27'd0, N_CS, N_DS, R_NW, DataOE, Start}, 32'h1C);
    check("dataout_holds", {24'd0, DataOut}, 32'hA5);

    // Single read from requester 2
    set_req(2, 1'b1, 8'h10, 8'h00);
    expect_cycle(2, 1'b1, 8'h10, 8'h00);
    req[2] = 1'b1;
    wait_ack(2, 20);
    req[2] = 1'b0;
    repeat (2) @(negedge Clk);
    check("rdata_holds", {24'd0, rdata}, 32'h5A);

    // Address change and req drop after grant; short req1 pulse never granted
    set_req(3, 1'b0, 8'h77, 8'hC3);
    expect_cycle(3, 1'b0, 8'h77, 8'hC3);
    req[3] = 1'b1;
    wait_start(10);
    req_addr[31:24] = 8'hEE;
    req[3] = 1'b0;
    set_req(1, 1'b0, 8'h21, 8'h12);
    req[1] = 1'b1;
    @(negedge Clk);
    req[1] = 1'b0;
    wait_ack(3, 20);
    s0 = start_cnt;
    repeat (8) @(negedge Clk);
    check("dropped_req_ignored", start_cnt, s0);
    check("rdata_kept_by_write", {24'd0, rdata}, 32'h5A);

    // All four held: 0,1,2,3 then 0 again
    set_req(0, 1'b0, 8'h01, 8'h11);
    set_req(1, 1'b1, 8'h02, 8'h00);
    set_req(2, 1'b0, 8'h03, 8'h33);
    set_req(3, 1'b1, 8'h04, 8'h00);
    expect_cycle(0, 1'b0, 8'h01, 8'h11);
    expect_cycle(1, 1'b1, 8'h02, 8'h00);
    expect_cycle(2, 1'b0, 8'h03, 8'h33);
    expect_cycle(3, 1'b1, 8'h04, 8'h00);
    expect_cycle(0, 1'b0, 8'h01, 8'h11);
    req = 4'hF;
    wait_ack(0, 20);
    wait_ack(1, 20);
    wait_ack(2, 20);
    wait_ack(3, 20);
    wait_ack(0, 20);
    req = '0;
    repeat (3) @(negedge Clk);

    // Reset in the second STROBE cycle of a req2 read
    set_req(2, 1'b1, 8'h20, 8'h00);
    expect_cycle(2, 1'b1, 8'h20, 8'h00);
    req[2] = 1'b1;
    wait_start(10);
    @(negedge Clk);
    @(negedge Clk);
    check("abort_in_strobe", {31'd0, N_DS}, 32'd0);
    N_Reset = 1'b0;
    req[2]  = 1'b0;
    @(negedge Clk);
    check("abort_strobes_high", {30'd0, N_CS, N_DS}, 32'd3);
    check("abort_no_ack", {28'd0, ack}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    @(negedge Clk);
    check("abort_rst_vals", {8'd0, AddrBus, DataOut, rdata}, 32'd0);
    check("abort_rst_ctl", {28'd0, R_NW, DataOE, Start, 1'b0}, 32'h8);
    exp_q.delete();
    last_rd = 8'h00;
    N_Reset = 1'b1;
    @(negedge Clk);

    // After reset requester 1 wins over 3
    set_req(1, 1'b0, 8'h55, 8'h66);
    set_req(3, 1'b0, 8'h99, 8'hAA);
    expect_cycle(1, 1'b0, 8'h55, 8'h66);
    expect_cycle(3, 1'b0, 8'h99, 8'hAA);
    req[1] = 1'b1;
    req[3] = 1'b1;
    wait_ack(1, 20);
    req[1] = 1'b0;
    wait_ack(3, 20);
    req[3] = 1'b0;
    repeat (3) @(negedge Clk);

    // Strobe length at WAIT_CYCLES=1 and 15
    set_req(0, 1'b1, 8'h42, 8'h00);
    r1v[0] = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (!a1_ack[0] && n < 20);
    check("w1_ack_seen", {31'd0, a1_ack[0]}, 32'd1);
    r1v = '0;
    r15v[0] = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (!a15_ack[0] && n < 40);
    check("w15_ack_seen", {31'd0, a15_ack[0]}, 32'd1);
    r15v = '0;
    repeat (3) @(negedge Clk);
    check("w1_strobe_checked", ds1_checks, 1);
    check("w15_strobe_checked", ds15_checks, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
